// File: rtl/validation_reader.sv
// Walks a range of validation-memory entries and compares each one against one engine result.
// Latency: 4 cycles per entry when res_valid is held high, plus 1 cycle to start and 1 cycle to finish.
// Backpressure: stalls in WAIT_RES until res_valid; only one memory read is outstanding at a time.
module validation_reader #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16,
    parameter int TOLERANCE = 0,
    parameter int TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     count,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                mem_ready,
    input  logic                res_valid,
    input  logic [DATA_W-1:0]   res_data,
    output logic                res_ready,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout_err,
    output logic [ADDR_W:0]     mismatch_count,
    output logic [ADDR_W-1:0]   first_mismatch_addr
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_MEM,
        WAIT_RES,
        NEXT,
        FINISH
    } state_t;

    // Wide enough to hold TIMEOUT itself, even when TIMEOUT is 0.
    localparam int                TMO_W   = $clog2(TIMEOUT + 2);
    localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT);
    localparam logic [DATA_W:0]   TOL_V   = (DATA_W + 1)'(TOLERANCE);
    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                pass_q, pass_d;
    logic                tmo_err_q, tmo_err_d;
    logic [ADDR_W:0]     mm_cnt_q, mm_cnt_d;
    logic [ADDR_W-1:0]   first_q, first_d;

    // Difference at DATA_W+1 bits cannot overflow, so its magnitude always fits too.
    logic signed [DATA_W:0] diff;
    logic [DATA_W:0]        abs_diff;
    logic                   mismatch;

    // Signed result-minus-expected magnitude check against the tolerance window.
    always_comb begin
        diff     = $signed({res_data[DATA_W-1], res_data}) - $signed({exp_q[DATA_W-1], exp_q});
        abs_diff = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
        mismatch = (abs_diff > TOL_V);
    end

    // Next-state and datapath updates for the walk FSM.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        exp_d     = exp_q;
        tmo_d     = tmo_q;
        pass_d    = pass_q;
        tmo_err_d = tmo_err_q;
        mm_cnt_d  = mm_cnt_q;
        first_d   = first_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pass_d    = 1'b1;
                    tmo_err_d = 1'b0;
                    mm_cnt_d  = '0;
                    first_d   = '0;
                    if (count == '0) begin
                        state_d = FINISH;
                    end else begin
                        ptr_d   = base_addr;
                        rem_d   = count;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                tmo_d   = '0;
                state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (mem_ready) begin
                    exp_d   = mem_data;
                    state_d = WAIT_RES;
                end else if (tmo_q == TMO_MAX) begin
                    tmo_err_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = FINISH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_RES: begin
                if (res_valid) begin
                    if (mismatch) begin
                        pass_d = 1'b0;
                        if (mm_cnt_q == '0) begin
                            first_d = ptr_q;
                        end
                        if (mm_cnt_q != '1) begin
                            mm_cnt_d = mm_cnt_q + 1'b1;
                        end
                    end
                    state_d = NEXT;
                end
            end
            NEXT: begin
                ptr_d   = ptr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == REM_ONE) ? FINISH : REQ;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run and drops in-flight responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            exp_q     <= '0;
            tmo_q     <= '0;
            pass_q    <= 1'b1;
            tmo_err_q <= 1'b0;
            mm_cnt_q  <= '0;
            first_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            exp_q     <= exp_d;
            tmo_q     <= tmo_d;
            pass_q    <= pass_d;
            tmo_err_q <= tmo_err_d;
            mm_cnt_q  <= mm_cnt_d;
            first_q   <= first_d;
        end
    end

    assign mem_addr            = ptr_q;
    assign mem_rd_en           = (state_q == REQ);
    assign mem_wr_en           = 1'b0;
    assign res_ready           = (state_q == WAIT_RES);
    assign busy                = (state_q != IDLE);
    assign done                = (state_q == FINISH);
    assign pass                = pass_q;
    assign timeout_err         = tmo_err_q;
    assign mismatch_count      = mm_cnt_q;
    assign first_mismatch_addr = first_q;

endmodule

// File: tb/tb_validation_reader.sv
// Randomized bench for validation_reader with a memory model, engine driver and scoreboard.
// Latency: checks 4 cycles per entry and TIMEOUT+2 from request to done on timeout.
// Backpressure: engine valid is randomly withheld; reads must never overlap a pending entry.
module tb_validation_reader;

    localparam int AW  = 11;
    localparam int DW  = 16;
    localparam int TOL = 2;
    localparam int TMO = 15;
    localparam int N   = 2048;

    typedef struct {
        bit pass;
        bit tmo;
        int mm;
        int first;
        int lat;
    } verdict_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_ready;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timeout_err;
    logic [AW:0]   mismatch_count;
    logic [AW-1:0] first_mismatch_addr;

    validation_reader #(
        .ADDR_W(AW), .DATA_W(DW), .TOLERANCE(TOL), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_data(mem_data), .mem_ready(mem_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .done(done), .pass(pass), .timeout_err(timeout_err),
        .mismatch_count(mismatch_count), .first_mismatch_addr(first_mismatch_addr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic signed [DW-1:0] mem [N];
    logic signed [DW-1:0] res_q[$];
    logic signed [DW-1:0] forced[$];
    int                   addr_q[$];
    verdict_t             vq[$];

    bit mem_stall   = 0;
    int stall_pct   = 0;
    int hold_n      = 0;
    int done_cnt    = 0;
    bit outstanding = 0;
    bit mem_got     = 0;
    bit run_rd_seen = 0;
    int first_rd    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: one-cycle ready pulse in the cycle after a sampled read.
    bit pend;
    int pa;
    initial begin
        mem_ready = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk);
            pend = mem_rd_en && !mem_stall && !reset;
            pa   = int'(mem_addr);
            @(posedge clk);
            #1;
            mem_ready = pend;
            mem_data  = pend ? mem[pa] : 16'($urandom);
        end
    end

    // Engine result stream: presents the head of res_q, valid randomly withheld.
    bit acc = 0;
    logic signed [DW-1:0] drop;
    initial begin
        res_valid = 1'b0;
        res_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (acc && res_q.size() > 0) drop = res_q.pop_front();
            acc = 0;
            if (res_q.size() == 0) begin
                res_valid = 1'b0;
            end else if (hold_n > 0 && res_ready) begin
                hold_n--;
                res_valid = 1'b0;
            end else begin
                res_valid = ($urandom_range(0, 99) >= stall_pct);
            end
            res_data = (res_q.size() > 0) ? res_q[0] : '0;
            @(negedge clk);
            acc = res_valid && res_ready;
        end
    end

    // Monitor: read addresses, handshake ordering and end-of-run verdicts.
    verdict_t v_mon;
    always @(negedge clk) begin
        if (!reset) begin
            if (res_ready) chk("res_ready_before_mem_data", int'(mem_got), 1);
            if (mem_ready && outstanding) mem_got = 1;
            if (res_valid && res_ready) begin
                outstanding = 0;
                mem_got     = 0;
            end
            if (mem_rd_en) begin
                chk("read_while_entry_pending", int'(outstanding), 0);
                outstanding = 1;
                if (!run_rd_seen) begin
                    first_rd    = cyc;
                    run_rd_seen = 1;
                end
                checks++;
                if (addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_read actual_addr=%0d required=no read", mem_addr);
                end else if (int'(mem_addr) != addr_q[0]) begin
                    failures++;
                    $display("FAIL mem_addr actual=%0d required=%0d", mem_addr, addr_q[0]);
                    void'(addr_q.pop_front());
                end else begin
                    void'(addr_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (vq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    v_mon = vq.pop_front();
                    chk("pass", int'(pass), int'(v_mon.pass));
                    chk("timeout_err", int'(timeout_err), int'(v_mon.tmo));
                    chk("mismatch_count", int'(mismatch_count), v_mon.mm);
                    chk("first_mismatch_addr", int'(first_mismatch_addr), v_mon.first);
                    chk("busy_at_done", int'(busy), 1);
                    chk("reads_not_issued", addr_q.size(), 0);
                    chk("mem_wr_en", int'(mem_wr_en), 0);
                    if (v_mon.lat >= 0) chk("done_latency", cyc - first_rd, v_mon.lat);
                end
                run_rd_seen = 0;
                outstanding = 0;
                mem_got     = 0;
            end
        end
    end

    // One run: the reference model builds the expected reads and verdict, then start is pulsed.
    task automatic run(input int base, input int cnt, input bit tmo_mode,
                       input bit restart, input int dmax);
        verdict_t v;
        int mm = 0, first = 0, a, d, k, d0;
        logic signed [DW-1:0] r;
        if (tmo_mode) begin
            mem_stall = 1;
            addr_q.push_back(base);
            v = '{pass: 0, tmo: 1, mm: 0, first: 0, lat: TMO + 2};
        end else begin
            for (int i = 0; i < cnt; i++) begin
                a = (base + i) % N;
                addr_q.push_back(a);
                if (forced.size() > 0) r = forced.pop_front();
                else if (dmax < 0) r = 16'($urandom);
                else r = 16'(int'(mem[a]) + int'($urandom_range(0, 2 * dmax)) - dmax);
                res_q.push_back(r);
                d = int'(r) - int'(mem[a]);
                if ((d < 0 ? -d : d) > TOL) begin
                    if (mm == 0) first = a;
                    mm++;
                end
            end
            v.pass  = (mm == 0);
            v.tmo   = 0;
            v.mm    = mm;
            v.first = first;
            v.lat   = (stall_pct == 0 && hold_n == 0 && cnt > 0) ? 4 * cnt : -1;
        end
        vq.push_back(v);
        d0        = done_cnt;
        base_addr = AW'(base);
        count     = (AW + 1)'(cnt);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        if (restart) begin
            repeat (6) tick();
            base_addr = AW'($urandom);
            count     = 1;
            start     = 1'b1;
            tick();
            start     = 1'b0;
        end
        k = 0;
        while (done_cnt == d0 && k < 20000) begin
            tick();
            k++;
        end
        chk("done_within_budget", int'(done_cnt != d0), 1);
        mem_stall = 0;
        hold_n    = 0;
        res_q.delete();
        repeat (2) tick();
    endtask

    int rb, rc, rd, k;
    initial begin
        for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        repeat (3) tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pass", int'(pass), 1);
        chk("reset_timeout_err", int'(timeout_err), 0);
        chk("reset_mismatch_count", int'(mismatch_count), 0);
        chk("reset_first_addr", int'(first_mismatch_addr), 0);
        chk("reset_rd_en", int'(mem_rd_en) + int'(mem_wr_en) + int'(res_ready), 0);
        chk("reset_mem_addr", int'(mem_addr), 0);
        reset = 1'b0;
        tick();

        // All match at 10..13.
        for (int i = 0; i < 4; i++) mem[10 + i] = 16'(100 + i);
        run(10, 4, 0, 0, 0);

        // Tolerance edge: -7 vs -5 is inside, -8 vs -5 is outside.
        mem[500] = -16'sd5; mem[501] = -16'sd5;
        forced.push_back(-16'sd7); forced.push_back(-16'sd8);
        run(500, 2, 0, 0, 0);

        // Address wrap.
        run(2046, 4, 0, 0, 3);

        // Timeout with memory silent.
        run(300, 3, 1, 0, 0);

        // Backpressure with a start re-pulsed mid-run.
        hold_n = 5;
        run(40, 6, 0, 1, 3);

        // Reset during WAIT_MEM.
        addr_q.push_back(900);
        for (int i = 0; i < 5; i++) res_q.push_back(mem[900 + i]);
        base_addr = 900; count = 5; start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!outstanding && k < 50) begin
            tick();
            k++;
        end
        chk("read_before_reset", int'(outstanding), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrun_reset_busy", int'(busy), 0);
        chk("midrun_reset_pass", int'(pass), 1);
        chk("midrun_reset_res_ready", int'(res_ready), 0);
        res_q.delete();
        addr_q.delete();
        outstanding = 0; mem_got = 0; run_rd_seen = 0;
        repeat (20) tick();
        chk("idle_after_reset", int'(busy), 0);

        // Zero count.
        run(7, 0, 0, 0, 0);

        // Randomized runs.
        for (int t = 0; t < 10; t++) begin
            stall_pct = $urandom_range(0, 1) ? 0 : int'($urandom_range(10, 60));
            rb = $urandom_range(0, N - 1);
            rc = $urandom_range(1, 30);
            case ($urandom_range(0, 3))
                0: rd = 0;
                1: rd = 2;
                2: rd = 4;
                default: rd = -1;
            endcase
            run(rb, rc, 0, 0, rd);
        end
        stall_pct = 0;

        // Full memory sweep.
        run(int'($urandom_range(0, N - 1)), N, 0, 0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
